// File: rtl/rtc_pkg.sv
// Shared limits and display helpers for the real-time-clock counter chain.
package rtc_pkg;

    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;
    localparam int HR_MAX  = 23;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd_t;

    function automatic bcd_t split_bcd(input logic [6:0] v);
        bcd_t r;
        r.tens  = 4'(v / 7'd10);
        r.units = 4'(v % 7'd10);
        return r;
    endfunction

    // Midnight shows as 12, afternoon hours fold back by 12.
    function automatic logic [4:0] hr_12h_map(input logic [4:0] h);
        logic [4:0] r;
        if (h == 5'd0)
            r = 5'd12;
        else if (h > 5'd12)
            r = h - 5'd12;
        else
            r = h;
        return r;
    endfunction

endpackage

// File: rtl/mod_updown_counter.sv
// Modulo-MOD up/down counter with parallel load and a direction-aware terminal flag.
module mod_updown_counter #(
    parameter int W   = 6,
    parameter int MOD = 60
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    output logic [W-1:0] q,
    output logic         at_terminal
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    assign at_terminal = up ? (q_q == W'(MOD - 1)) : (q_q == '0);
    assign q           = q_q;

    always_comb begin
        q_d = q_q;
        if (ld)
            q_d = ld_val;
        else if (en) begin
            if (up)
                q_d = at_terminal ? '0 : q_q + 1'b1;
            else
                q_d = at_terminal ? W'(MOD - 1) : q_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            q_q <= '0;
        else
            q_q <= q_d;
    end

endmodule

// File: rtl/rtc_counter_chain.sv
// Clock-of-day counter: 1 Hz prescaler feeding a seconds/minutes/hours modulo chain,
// with adjust, validated load, 12/24-hour display and registered status pulses.
module rtc_counter_chain
    import rtc_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000,
    parameter int DIV_W    = $clog2(TICK_DIV + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       adj_min,
    input  logic       adj_hr,
    input  logic       up_down,
    input  logic       mode_12h,
    input  logic       load,
    input  logic [4:0] load_h,
    input  logic [5:0] load_m,
    input  logic [5:0] load_s,
    output logic [2:0] sec_tens,
    output logic [3:0] sec_units,
    output logic [2:0] min_tens,
    output logic [3:0] min_units,
    output logic [1:0] hr_tens,
    output logic [3:0] hr_units,
    output logic       pm,
    output logic       sec_tick,
    output logic       day_wrap,
    output logic       load_err
);

    logic [DIV_W-1:0] pcnt_q, pcnt_d;
    logic             sec_tick_q, day_wrap_q, load_err_q;
    logic             tick, load_ok;
    logic             s_en, m_en, h_en;
    logic             s_term, m_term, h_term;
    logic [5:0]       s_q, m_q;
    logic [4:0]       h_q;
    logic [4:0]       hr_disp;
    bcd_t             s_bcd, m_bcd, h_bcd;

    assign tick    = run && (pcnt_q == DIV_W'(TICK_DIV - 1));
    assign load_ok = load && (load_h <= 5'(HR_MAX)) && (load_m <= 6'(MIN_MAX))
                          && (load_s <= 6'(SEC_MAX));

    // Any load, accepted or rejected, suppresses ticks and adjusts for that cycle.
    assign s_en = ~load & tick;
    assign m_en = ~load & (run ? (tick & s_term) : adj_min);
    assign h_en = ~load & (run ? (tick & s_term & m_term) : adj_hr);

    always_comb begin
        pcnt_d = pcnt_q;
        if (load)
            pcnt_d = load_ok ? '0 : pcnt_q;
        else if (!run || tick)
            pcnt_d = '0;
        else
            pcnt_d = pcnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q     <= '0;
            sec_tick_q <= 1'b0;
            day_wrap_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            pcnt_q     <= pcnt_d;
            sec_tick_q <= s_en;
            day_wrap_q <= h_en & h_term;
            load_err_q <= load & ~load_ok;
        end
    end

    mod_updown_counter #(.W(6), .MOD(SEC_MAX + 1)) u_sec (
        .clk(clk), .rst(rst), .en(s_en), .up(up_down), .ld(load_ok), .ld_val(load_s),
        .q(s_q), .at_terminal(s_term)
    );

    mod_updown_counter #(.W(6), .MOD(MIN_MAX + 1)) u_min (
        .clk(clk), .rst(rst), .en(m_en), .up(up_down), .ld(load_ok), .ld_val(load_m),
        .q(m_q), .at_terminal(m_term)
    );

    mod_updown_counter #(.W(5), .MOD(HR_MAX + 1)) u_hr (
        .clk(clk), .rst(rst), .en(h_en), .up(up_down), .ld(load_ok), .ld_val(load_h),
        .q(h_q), .at_terminal(h_term)
    );

    always_comb begin
        hr_disp = mode_12h ? hr_12h_map(h_q) : h_q;
        s_bcd   = split_bcd(7'(s_q));
        m_bcd   = split_bcd(7'(m_q));
        h_bcd   = split_bcd(7'(hr_disp));
    end

    assign sec_tens  = s_bcd.tens[2:0];
    assign sec_units = s_bcd.units;
    assign min_tens  = m_bcd.tens[2:0];
    assign min_units = m_bcd.units;
    assign hr_tens   = h_bcd.tens[1:0];
    assign hr_units  = h_bcd.units;
    assign pm        = (h_q >= 5'd12);
    assign sec_tick  = sec_tick_q;
    assign day_wrap  = day_wrap_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_rtc_counter_chain.sv
// Directed vector table plus randomized run against a seconds-of-day reference model.
module tb_rtc_counter_chain;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst, run, adj_min, adj_hr, up_down, mode_12h, load;
    logic [4:0] load_h;
    logic [5:0] load_m, load_s;
    logic [2:0] sec_tens, min_tens;
    logic [3:0] sec_units, min_units, hr_units;
    logic [1:0] hr_tens;
    logic       pm, sec_tick, day_wrap, load_err;

    int checks = 0;
    int errors = 0;

    rtc_counter_chain #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .run(run), .adj_min(adj_min), .adj_hr(adj_hr),
        .up_down(up_down), .mode_12h(mode_12h), .load(load),
        .load_h(load_h), .load_m(load_m), .load_s(load_s),
        .sec_tens(sec_tens), .sec_units(sec_units), .min_tens(min_tens),
        .min_units(min_units), .hr_tens(hr_tens), .hr_units(hr_units),
        .pm(pm), .sec_tick(sec_tick), .day_wrap(day_wrap), .load_err(load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst, run, amin, ahr, up, mode, load;
        int   lh, lm, ls;
        int   eh, em, es;
        logic etick, edw, eerr;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic r, logic rn, logic am, logic ah, logic u, logic md,
                                logic ld, int lh, int lm, int ls, int eh, int em, int es,
                                logic et, logic ed, logic ee);
        vec_t v;
        v.rst = r; v.run = rn; v.amin = am; v.ahr = ah; v.up = u; v.mode = md; v.load = ld;
        v.lh = lh; v.lm = lm; v.ls = ls; v.eh = eh; v.em = em; v.es = es;
        v.etick = et; v.edw = ed; v.eerr = ee;
        tbl.push_back(v);
    endfunction

    function automatic logic [23:0] expect_vec(int h, int m, int s, logic md,
                                               logic t, logic d, logic e);
        int hd;
        hd = md ? ((h % 12 == 0) ? 12 : h % 12) : h;
        return {3'(s / 10), 4'(s % 10), 3'(m / 10), 4'(m % 10), 2'(hd / 10), 4'(hd % 10),
                (h >= 12), t, d, e};
    endfunction

    function automatic logic [23:0] actual_vec();
        return {sec_tens, sec_units, min_tens, min_units, hr_tens, hr_units,
                pm, sec_tick, day_wrap, load_err};
    endfunction

    task automatic compare(string name, logic [23:0] exp_v);
        logic [23:0] act;
        act = actual_vec();
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got s=%0d%0d m=%0d%0d h=%0d%0d pm=%b tk=%b dw=%b er=%b, want s=%0d%0d m=%0d%0d h=%0d%0d pm=%b tk=%b dw=%b er=%b",
                     name, act[23:21], act[20:17], act[16:14], act[13:10], act[9:8], act[7:4],
                     act[3], act[2], act[1], act[0],
                     exp_v[23:21], exp_v[20:17], exp_v[16:14], exp_v[13:10], exp_v[9:8],
                     exp_v[7:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
        end
    endtask

    task automatic drive(logic r, logic rn, logic am, logic ah, logic u, logic md,
                         logic ld, int lh, int lm, int ls);
        rst = r; run = rn; adj_min = am; adj_hr = ah; up_down = u; mode_12h = md;
        load = ld; load_h = 5'(lh); load_m = 6'(lm); load_s = 6'(ls);
    endtask

    // Reference model: time kept as seconds since midnight.
    int  mt, mp;
    logic xt, xd, xe;

    function automatic void model_step(logic r, logic rn, logic am, logic ah, logic u,
                                       logic ld, int lh, int lm, int ls);
        int h, m;
        xt = 0; xd = 0; xe = 0;
        if (r) begin
            mt = 0; mp = 0;
        end else if (ld) begin
            if (lh <= 23 && lm <= 59 && ls <= 59) begin
                mt = lh * 3600 + lm * 60 + ls; mp = 0;
            end else
                xe = 1;
        end else if (rn) begin
            if (mp == TD - 1) begin
                mp = 0; xt = 1;
                xd = u ? (mt == 86399) : (mt == 0);
                mt = u ? (mt + 1) % 86400 : (mt + 86399) % 86400;
            end else
                mp++;
        end else begin
            mp = 0;
            h = mt / 3600; m = (mt / 60) % 60;
            if (am) m = (m + (u ? 1 : 59)) % 60;
            if (ah) begin
                xd = u ? (h == 23) : (h == 0);
                h = (h + (u ? 1 : 23)) % 24;
            end
            mt = h * 3600 + m * 60 + mt % 60;
        end
    endfunction

    initial begin
        drive(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);

        add(1,0,0,0,1,0,0, 0,0,0,   0,0,0, 0,0,0);
        for (int i = 1; i <= 8; i++)
            add(0,1,0,0,1,0,0, 0,0,0, 0,0,i/4, (i%4==0),0,0);
        add(0,1,0,0,1,0,1, 23,59,59, 23,59,59, 0,0,0);
        for (int i = 0; i < 3; i++) add(0,1,0,0,1,0,0, 0,0,0, 23,59,59, 0,0,0);
        add(0,1,0,0,1,0,0, 0,0,0,   0,0,0, 1,1,0);
        add(0,1,0,0,0,0,1, 0,0,0,   0,0,0, 0,0,0);
        for (int i = 0; i < 3; i++) add(0,1,0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0);
        add(0,1,0,0,0,0,0, 0,0,0,   23,59,59, 1,1,0);
        add(0,0,0,0,1,0,1, 10,59,30, 10,59,30, 0,0,0);
        add(0,0,1,0,1,0,0, 0,0,0,   10,0,30, 0,0,0);
        add(0,0,0,0,0,0,1, 0,0,30,  0,0,30, 0,0,0);
        add(0,0,1,1,0,0,0, 0,0,0,   23,59,30, 0,1,0);
        add(0,0,0,0,1,0,1, 5,6,7,   5,6,7, 0,0,0);
        add(0,0,0,0,1,0,1, 5,60,7,  5,6,7, 0,0,1);
        add(0,0,0,0,1,0,0, 0,0,0,   5,6,7, 0,0,0);
        add(0,0,0,0,1,0,1, 23,6,7,  23,6,7, 0,0,0);
        add(0,0,0,0,1,1,1, 0,1,2,   0,1,2, 0,0,0);
        add(0,0,0,0,1,1,1, 13,1,2,  13,1,2, 0,0,0);
        add(0,0,0,0,1,1,1, 12,1,2,  12,1,2, 0,0,0);
        add(0,0,0,0,1,0,0, 0,0,0,   12,1,2, 0,0,0);
        add(0,0,0,0,1,1,0, 0,0,0,   12,1,2, 0,0,0);
        // Load collides with the tick cycle: load wins and the prescaler restarts.
        for (int i = 0; i < 3; i++) add(0,1,0,0,1,0,0, 0,0,0, 12,1,2, 0,0,0);
        add(0,1,0,0,1,0,1, 1,2,3,   1,2,3, 0,0,0);
        for (int i = 0; i < 3; i++) add(0,1,0,0,1,0,0, 0,0,0, 1,2,3, 0,0,0);
        add(0,1,0,0,1,0,0, 0,0,0,   1,2,4, 1,0,0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].run, tbl[i].amin, tbl[i].ahr, tbl[i].up, tbl[i].mode,
                  tbl[i].load, tbl[i].lh, tbl[i].lm, tbl[i].ls);
            @(posedge clk);
            #1;
            compare($sformatf("vec%0d", i),
                    expect_vec(tbl[i].eh, tbl[i].em, tbl[i].es, tbl[i].mode,
                               tbl[i].etick, tbl[i].edw, tbl[i].eerr));
        end

        // Randomized run against the model, starting from reset.
        for (int c = 0; c < 1500; c++) begin
            logic r, rn, am, ah, u, md, ld;
            int lh, lm, ls;
            r  = (c == 0) || ($urandom_range(0, 299) == 0);
            rn = ($urandom_range(0, 3) != 0);
            am = ($urandom_range(0, 3) == 0);
            ah = ($urandom_range(0, 3) == 0);
            u  = ($urandom_range(0, 2) != 0);
            md = $urandom_range(0, 1);
            ld = ($urandom_range(0, 14) == 0);
            case ($urandom_range(0, 3))
                0: begin lh = 23; lm = 59; ls = 59 - $urandom_range(0, 2); end
                1: begin lh = 0;  lm = 0;  ls = $urandom_range(0, 2); end
                default: begin
                    lh = $urandom_range(0, 31); lm = $urandom_range(0, 63);
                    ls = $urandom_range(0, 63);
                end
            endcase
            drive(r, rn, am, ah, u, md, ld, lh, lm, ls);
            model_step(r, rn, am, ah, u, ld, lh, lm, ls);
            @(posedge clk);
            #1;
            compare($sformatf("rand%0d", c),
                    expect_vec(mt / 3600, (mt / 60) % 60, mt % 60, md, xt, xd, xe));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
